// File: rtl/depth_lut_pkg.sv
// depth_lut_pkg: shared state, mode and packing constants for the LUT loader.
package depth_lut_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} lut_ld_state_t;
  localparam logic [1:0] LUT_MODE_OFF   = 2'b00;
  localparam logic [1:0] LUT_MODE_READ  = 2'b01;
  localparam logic [1:0] LUT_MODE_WRITE = 2'b10;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);
endpackage

// File: rtl/depth_lut_loader_if.sv
// depth_lut_loader_if: byte stream handshake feeding the LUT loader.
interface depth_lut_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/lut_byte_packer.sv
// lut_byte_packer: packs bytes into zero-padded words and pulses when a word is ready.
module lut_byte_packer
  import depth_lut_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clr,
  input  logic                        i_push,
  input  logic                        i_last,
  input  logic [7:0]                  i_byte,
  output logic [1:0]                  o_lane,
  output logic                        o_valid,
  output logic [8*BYTES_PER_WORD-1:0] o_word
);
  logic [1:0]                  r_lane;
  logic [8*BYTES_PER_WORD-1:0] r_buf, w_buf, r_word;
  logic                        r_valid, w_emit;

  assign w_emit  = i_push && (r_lane == LAST_LANE || i_last);
  assign o_lane  = r_lane;
  assign o_valid = r_valid;
  assign o_word  = r_word;

  // r_buf is cleared after every emit, so lanes never filled stay zero
  always_comb begin
    w_buf = r_buf;
    w_buf[8*r_lane +: 8] = i_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane  <= '0;
      r_buf   <= '0;
      r_valid <= 1'b0;
      r_word  <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) r_word <= w_buf;
      if (i_clr || w_emit) begin
        r_lane <= '0;
        r_buf  <= '0;
      end else if (i_push) begin
        r_lane <= r_lane + 2'd1;
        r_buf  <= w_buf;
      end
    end
  end
endmodule

// File: rtl/depth_lut_loader.sv
// depth_lut_loader: streams bytes into sequential LUT word writes and drives the table mode.
module depth_lut_loader
  import depth_lut_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  depth_lut_loader_if.slave   s,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [31:0]         wr_data,
  output logic [1:0]          lut_mode,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     word_cnt
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  lut_ld_state_t   r_state, w_next;
  logic [ADDR_W:0] r_word_cnt, w_cnt_next, w_final;
  logic            r_done, r_err;
  logic            w_ready, w_start_ok, w_acc, w_drop, w_push, w_last;
  logic [1:0]      w_lane;

  assign w_ready    = r_state == LOAD;
  assign s.s_ready  = w_ready;
  assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
  assign w_acc      = s.s_valid && w_ready;
  // a word still on the write port counts as stored, so overflow is caught one byte early enough
  assign w_cnt_next = r_word_cnt + (ADDR_W+1)'(wr_en);
  assign w_drop     = w_acc && w_cnt_next == FULL;
  assign w_push     = w_acc && !w_drop;
  assign w_last     = w_acc && s.s_last;
  assign w_final    = w_cnt_next + (ADDR_W+1)'(w_push);
  assign wr_addr    = r_word_cnt[ADDR_W-1:0];
  assign word_cnt   = r_word_cnt;
  assign done       = r_done;
  assign err        = r_err;

  lut_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_ok),
    .i_push  (w_push),
    .i_last  (s.s_last),
    .i_byte  (s.s_data),
    .o_lane  (w_lane),
    .o_valid (wr_en),
    .o_word  (wr_data)
  );

  always_comb begin
    w_next   = r_state;
    lut_mode = LUT_MODE_OFF;
    if (w_start_ok) w_next = LOAD;
    else if (r_state == LOAD && w_last) w_next = (w_push && w_lane != LAST_LANE) ? FLUSH : DONE;
    else if (r_state == FLUSH) w_next = DONE;
    lut_mode = (r_state == LOAD || r_state == FLUSH) ? LUT_MODE_WRITE :
               (r_state == DONE && !r_err) ? LUT_MODE_READ : LUT_MODE_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_word_cnt <= '0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end else begin
        if (wr_en) r_word_cnt <= r_word_cnt + 1'b1;
        if (w_next == DONE && r_state != DONE) begin
          r_done <= 1'b1;
          r_err  <= r_err || w_drop || r_state == FLUSH || w_final != FULL;
        end else if (w_drop) begin
          r_err <= 1'b1;
        end
      end
    end
  end
endmodule
